// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: operand read ports, write handshake, clear control and debug read.
// The slave modport is the register file; the master modport is the datapath driving it.
interface regfile_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
  logic                           wr_en;
  logic [ADDR_WIDTH-1:0]          wr_addr;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic                           wr_ready;
  logic                           clear_req;
  logic                           clear_busy;
  logic                           clear_done;
  logic [ADDR_WIDTH-1:0]          debug_addr;
  logic [DATA_WIDTH-1:0]          debug_data;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, clear_req, debug_addr,
    input  rd_data, wr_ready, clear_busy, clear_done, debug_data
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, clear_req, debug_addr,
    output rd_data, wr_ready, clear_busy, clear_done, debug_data
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised multi-read-port register file with registered reads, debug read and sequential clear.
// Optional macro REGFILE_BYPASS_EN selects write-first operand reads; undefined gives read-first.
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic           clock,
  input  logic           reset,
  regfile_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  wr_ready_q;
  logic                  clear_busy_q;
  logic                  clear_done_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] debug_q;
  logic                  wr_accept;
  logic                  wr_to_array;

  assign wr_accept   = bus.wr_en && wr_ready_q;
  assign wr_to_array = wr_accept && !(ZERO_REG != 0 && bus.wr_addr == '0);

  // NOTE: every register below is updated with <= so all flops see pre-edge values of each other.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      clr_cnt      <= '0;
      wr_ready_q   <= 1'b1;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clear_done_q <= 1'b0;
          if (bus.clear_req) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            wr_ready_q   <= 1'b0;
            clear_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state        <= DONE;
            clr_cnt      <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          clear_done_q <= 1'b0;
          wr_ready_q   <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          clr_cnt      <= '0;
          wr_ready_q   <= 1'b1;
          clear_busy_q <= 1'b0;
          clear_done_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the array is reset on purpose: every entry must read 0 after reset, so this maps to flops.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_to_array) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rd_next;
    logic [DATA_WIDTH-1:0] rd_q;

    assign addr = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    // NOTE: rd_next gets a default before any condition so no latch can be inferred.
    always_comb begin
      rd_next = mem[addr];
      if (BYPASS && wr_accept && bus.wr_addr == addr) rd_next = bus.wr_data;
      if (ZERO_REG != 0 && addr == '0) rd_next = '0;
    end

    always_ff @(posedge clock) begin
      if (!reset) rd_q <= '0;
      else        rd_q <= rd_next;
    end

    assign bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

  // Debug port never bypasses: it always shows the array as it was before this edge's write.
  always_ff @(posedge clock) begin
    if (!reset)                                    debug_q <= '0;
    else if (ZERO_REG != 0 && bus.debug_addr == '0) debug_q <= '0;
    else                                           debug_q <= mem[bus.debug_addr];
  end

  assign bus.debug_data = debug_q;
  assign bus.wr_ready   = wr_ready_q;
  assign bus.clear_busy = clear_busy_q;
  assign bus.clear_done = clear_done_q;
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised multi-read-port register file for the processor datapath.
- Generalises the fixed 32x32 two-read-port file: configurable width, depth and read-port count, plus a single-clock debug read port.
- Adds a sequential clear engine that zeroes one entry per cycle and stalls writes while it runs.
- Used by the decode stage for operand fetch and by the writeback stage.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries
NUM_READ, 2, number of operand read ports
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is ordinary

Ports:
clock  input  1  sole clock; all state updates on posedge
reset  input  1  synchronous, active-low; sampled on posedge clock
rd_addr  input  NUM_READ*ADDR_WIDTH  packed read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  output  NUM_READ*DATA_WIDTH  packed registered read data, same packing
wr_en  input  1  write request
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
wr_ready  output  1  high when a write is accepted this cycle
clear_req  input  1  start sequential clear
clear_busy  output  1  clear engine running
clear_done  output  1  one-cycle pulse after last entry cleared
debug_addr  input  ADDR_WIDTH  debug read address
debug_data  output  DATA_WIDTH  registered debug read data

Behaviour:
- Reset (reset==0 at posedge): all DEPTH entries <= 0; rd_data, debug_data <= 0; FSM <= IDLE; clear counter <= 0; clear_done <= 0. Reset overrides every other input, including mid-clear.
- Write: accepted at posedge when wr_en && wr_ready. Array[wr_addr] <= wr_data, except when ZERO_REG=1 and wr_addr==0 (write silently dropped, still counts as accepted).
- A write with wr_ready==0 is dropped. The source holds the request until wr_ready is high.
- Read latency: 1 cycle. At each posedge, each rd_data port k and debug_data load the array content at the sampled address.
- ZERO_REG=1: reads of address 0 always return 0.
- Same-edge write/read collision: governed by REGFILE_BYPASS_EN (see Optional Feature). The debug port is never bypassed; it always shows pre-write content.
- FSM states:
  - IDLE: wr_ready=1, clear_busy=0. clear_req=1 -> CLEAR with counter=0. A write in that same IDLE cycle is still accepted.
  - CLEAR: wr_ready=0, clear_busy=1. Each cycle array[counter] <= 0 and counter increments. When counter==DEPTH-1, clear that entry -> DONE. clear_req is ignored.
  - DONE: clear_done=1 for exactly one cycle, wr_ready=0 -> IDLE.
- Clear duration: DEPTH cycles in CLEAR plus 1 cycle in DONE. clear_busy is high for DEPTH cycles.
- Reads during CLEAR return current array contents: entries already cleared read 0, uncleared entries read their old value.
- Counter is ADDR_WIDTH bits. The terminal compare prevents wrap-around; the counter resets to 0 on entering CLEAR.
- Register outputs only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first): when a write is accepted at the same edge a read port samples wr_addr, that rd_data port loads wr_data. This does not apply to address 0 when ZERO_REG=1, which reads 0.
- Undefined (read-first): that rd_data port loads the old array value; the new value is visible from the following read.
- Behaviour is identical in all other cases.

Test Plan:
- Reset release, DATA_WIDTH=32, ADDR_WIDTH=5: read all 32 addresses on every port and debug -> all return 0x00000000, 1 cycle after each address.
- Write 0xDEADBEEF to r7, then read r7 on port 0 and port 1 next cycle -> both return 0xDEADBEEF; debug_addr=7 -> 0xDEADBEEF.
- ZERO_REG=1: write 0x12345678 to r0, then read r0 -> 0x00000000.
- Same-edge write 0xA5A5A5A5 to r3 with rd_addr port0=3 (r3 previously 0x1):
  - REGFILE_BYPASS_EN defined -> port0 returns 0xA5A5A5A5.
  - REGFILE_BYPASS_EN undefined -> port0 returns 0x00000001.
  - debug port (debug_addr=3) -> returns 0x00000001 in both builds.
- Fill r1..r31 with index values, pulse clear_req:
  - clear_busy high exactly 32 cycles; clear_done pulses once at cycle 33; wr_ready low for 33 cycles.
  - A write to r5 issued during CLEAR is dropped.
  - After the clear, every register reads 0.
- Drive reset low at cycle 10 of a clear -> next cycle FSM is IDLE, clear_busy=0, wr_ready=1, clear_done never pulses, all registers read 0.
